mmio_io_ctrl: RTL and testbench
===============================

Name: mmio_io_ctrl

Overview:
- Memory-mapped I/O responder on the data-memory bus of the pipelined ARM core; the processor datapath is the initiator.
- Decodes DM-stage address, write data, memWrite and memRead, and holds the board-facing registers: LEDs, debounced switches, 7-segment digits, a cycle timer and a status register.
- Returns combinational read data plus a hit flag, so the top level muxes readData between dmem and this block.

Parameters:
- N, 64, data/address bus width.
- BASE, 64'h8000, address of the first register.
- DEB_CYCLES, 4, consecutive identical synchronized samples required before a switch value is accepted (min 1).

Ports:
- clk  in  1  system clock (the divided core clock)
- reset  in  1  synchronous, active-high
- addr  in  N  DM byte address
- writeData  in  N  store data
- memWrite  in  1  store strobe, sampled on posedge clk
- memRead  in  1  load strobe
- readData  out  N  load data, combinational
- hit  out  1  addr decodes to a mapped register (combinational)
- i_sw  in  16  raw, asynchronous board switches
- o_led  out  16  LED register
- o_disp_bcd  out  16  four BCD/hex digits, [15:12] is the leftmost digit
- o_disp_blank  out  4  per-digit blank mask

Behaviour:
- Register map. Exact doubleword addresses only; any other address gives hit=0.
  - BASE+0x00 LED: read/write, bits [15:0].
  - BASE+0x08 SW: read-only, debounced value in [15:0].
  - BASE+0x10 DISP: read/write, [15:0] bcd, [19:16] blank.
  - BASE+0x18 TIMER: read/write, 64-bit.
  - BASE+0x20 STATUS: bit0 sw_changed; write-1-to-clear.
- Reads:
  - readData = zero-extended register value when memRead && hit, else 0.
  - No wait states.
  - A load and a store to the same register in the same cycle read the old value.
- Writes:
  - Take effect on posedge clk when memWrite && hit.
  - Unused upper bits are dropped and read back as 0.
  - Writes to SW are ignored.
  - memWrite with hit=0 has no effect.
- Switch path:
  - Two-flop synchronizer on i_sw.
  - A candidate register plus a counter track the synchronized value.
  - When the synchronized value differs from the candidate: candidate is loaded and the counter reset to 1.
  - Otherwise the counter increments and saturates at DEB_CYCLES.
  - When the counter reaches DEB_CYCLES and candidate != debounced value: debounced value <= candidate, and sw_changed is set in that same cycle.
  - Total latency from a stable i_sw change to the SW register update is 2 + DEB_CYCLES clocks.
  - Glitches shorter than DEB_CYCLES samples never reach SW.
- sw_changed:
  - Sticky.
  - A STATUS write with writeData[0]=1 clears it.
  - A set and a clear in the same cycle: set wins.
- TIMER:
  - Increments by 1 every clock and wraps from 2^64-1 to 0.
  - On a write, TIMER <= writeData in that cycle, with no increment; counting resumes on the next cycle.
- Reset values:
  - o_led = 0, o_disp_bcd = 0, o_disp_blank = 4'hF (all blank), TIMER = 0, sw_changed = 0.
  - Debounced SW, candidate, counter and synchronizer flops = 0.
  - Reset overrides any simultaneous write.
  - Reset mid-debounce discards the partial count.
  - hit and readData stay combinational during reset, and return reset values.

Test Plan:
- Reset: assert reset for 2 cycles -> o_led=0, o_disp_blank=4'hF, TIMER read = 0 on the first cycle after release, STATUS=0.
- LED/DISP: store 64'hFFFF_FFFF_0001_A5A5 to 0x8000 -> o_led=16'hA5A5, LED read = 64'h0000_0000_0000_A5A5. Store 64'h5_2025 to 0x8010 -> o_disp_bcd=16'h2025, o_disp_blank=4'h5.
- Debounce: i_sw 0 -> 16'h00F0 held steady (DEB_CYCLES=4) -> SW read = 0 through cycle 5, SW = 16'h00F0 at cycle 6, STATUS=1. A 2-cycle pulse to 16'h0001 -> SW unchanged, STATUS unchanged.
- STATUS clear: with sw_changed=1, store 1 to 0x8020 -> STATUS reads 0. Repeat so a new SW update lands in the clearing cycle -> STATUS stays 1.
- TIMER: store 64'hFFFF_FFFF_FFFF_FFFE to 0x8018 -> reads ...FFFE, then ...FFFF, then 0 on successive cycles.
- Decode: load 0x8028 and 0x8004 -> hit=0, readData=0. Store 0x1234 to 0x8008 -> SW unchanged. memRead=0 with addr=0x8000 -> readData=0, hit=1.

Source files
------------

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped board I/O responder on the data-memory bus: LEDs, debounced
// switches, 7-segment digits, a free-running cycle timer and a sticky status flag.
module mmio_io_ctrl #(
  parameter int             N          = 64,
  parameter logic [N-1:0]   BASE       = N'(64'h8000),
  parameter int             DEB_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  addr,
  input  logic [N-1:0]  writeData,
  input  logic          memWrite,
  input  logic          memRead,
  output logic [N-1:0]  readData,
  output logic          hit,
  input  logic [15:0]   i_sw,
  output logic [15:0]   o_led,
  output logic [15:0]   o_disp_bcd,
  output logic [3:0]    o_disp_blank
);

  localparam int            DEB_C   = (DEB_CYCLES < 1) ? 1 : DEB_CYCLES;
  localparam int            CW      = $clog2(DEB_C + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_C);

  localparam logic [N-1:0] A_LED    = BASE;
  localparam logic [N-1:0] A_SW     = BASE + N'(64'd8);
  localparam logic [N-1:0] A_DISP   = BASE + N'(64'd16);
  localparam logic [N-1:0] A_TIMER  = BASE + N'(64'd24);
  localparam logic [N-1:0] A_STATUS = BASE + N'(64'd32);

  logic          sel_led_s, sel_sw_s, sel_disp_s, sel_timer_s, sel_status_s;
  logic          we_led_s, we_disp_s, we_timer_s, we_status_s;
  logic [N-1:0]  rd_val_s;
  logic [N-1:0]  timer_r;
  logic          sw_changed_r;
  logic [15:0]   sync1_r, sync2_r, cand_r, sw_deb_r;
  logic [CW-1:0] cnt_r;
  logic [15:0]   cand_nxt_s;
  logic [CW-1:0] cnt_nxt_s;
  logic          deb_load_s;

  assign sel_led_s    = (addr == A_LED);
  assign sel_sw_s     = (addr == A_SW);
  assign sel_disp_s   = (addr == A_DISP);
  assign sel_timer_s  = (addr == A_TIMER);
  assign sel_status_s = (addr == A_STATUS);
  assign hit = sel_led_s | sel_sw_s | sel_disp_s | sel_timer_s | sel_status_s;

  assign we_led_s    = memWrite & sel_led_s;
  assign we_disp_s   = memWrite & sel_disp_s;
  assign we_timer_s  = memWrite & sel_timer_s;
  assign we_status_s = memWrite & sel_status_s;

  // Read mux: registers zero-extended, gated by memRead so idle cycles return 0.
  always_comb begin
    rd_val_s = {N{1'b0}};
    if (sel_led_s) begin
      rd_val_s = N'(o_led);
    end else if (sel_sw_s) begin
      rd_val_s = N'(sw_deb_r);
    end else if (sel_disp_s) begin
      rd_val_s = N'({o_disp_blank, o_disp_bcd});
    end else if (sel_timer_s) begin
      rd_val_s = timer_r;
    end else if (sel_status_s) begin
      rd_val_s = N'(sw_changed_r);
    end else begin
      rd_val_s = {N{1'b0}};
    end
    readData = (memRead && hit) ? rd_val_s : {N{1'b0}};
  end

  // Debounce next-state: the accept decision uses the post-update count so the
  // debounced value moves on the very cycle the count reaches DEB_CYCLES.
  always_comb begin
    cand_nxt_s = cand_r;
    cnt_nxt_s  = cnt_r;
    if (sync2_r != cand_r) begin
      cand_nxt_s = sync2_r;
      cnt_nxt_s  = CW'(1);
    end else if (cnt_r != DEB_MAX) begin
      cnt_nxt_s = cnt_r + CW'(1);
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  assign deb_load_s = (cnt_nxt_s == DEB_MAX) && (cand_nxt_s != sw_deb_r);

  // All state: synchronous reset wins over any simultaneous write.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_led        <= 16'h0000;
      o_disp_bcd   <= 16'h0000;
      o_disp_blank <= 4'hF;
      timer_r      <= {N{1'b0}};
      sw_changed_r <= 1'b0;
      sync1_r      <= 16'h0000;
      sync2_r      <= 16'h0000;
      cand_r       <= 16'h0000;
      sw_deb_r     <= 16'h0000;
      cnt_r        <= {CW{1'b0}};
    end else begin
      if (we_led_s) begin
        o_led <= writeData[15:0];
      end
      if (we_disp_s) begin
        o_disp_bcd   <= writeData[15:0];
        o_disp_blank <= writeData[19:16];
      end
      timer_r <= we_timer_s ? writeData : (timer_r + N'(64'd1));
      sync1_r <= i_sw;
      sync2_r <= sync1_r;
      cand_r  <= cand_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (deb_load_s) begin
        sw_deb_r <= cand_nxt_s;
      end
      // A new switch update beats a same-cycle clear.
      if (deb_load_s) begin
        sw_changed_r <= 1'b1;
      end else if (we_status_s && writeData[0]) begin
        sw_changed_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Directed self-checking bench for mmio_io_ctrl with hand-computed expectations.
module tb_mmio_io_ctrl;

  logic        clk;
  logic        reset;
  logic [63:0] addr;
  logic [63:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [63:0] readData;
  logic        hit;
  logic [15:0] i_sw;
  logic [15:0] o_led;
  logic [15:0] o_disp_bcd;
  logic [3:0]  o_disp_blank;

  int passed = 0;
  int total  = 0;

  mmio_io_ctrl #(.N(64), .BASE(64'h8000), .DEB_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .writeData    (writeData),
    .memWrite     (memWrite),
    .memRead      (memRead),
    .readData     (readData),
    .hit          (hit),
    .i_sw         (i_sw),
    .o_led        (o_led),
    .o_disp_bcd   (o_disp_bcd),
    .o_disp_blank (o_disp_blank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called just after a posedge; store commits on the next posedge.
  task automatic wr(input logic [63:0] a, input logic [63:0] d);
    addr      = a;
    writeData = d;
    memWrite  = 1'b1;
    memRead   = 1'b0;
    @(posedge clk);
    #1;
    memWrite  = 1'b0;
  endtask

  // Combinational load check, stays inside the current cycle.
  task automatic rd(input string tag, input logic [63:0] a, input logic [63:0] exp, input logic exp_hit);
    addr    = a;
    memRead = 1'b1;
    #2;
    check(tag, readData, exp);
    check({tag, "_hit"}, {63'd0, hit}, {63'd0, exp_hit});
    memRead = 1'b0;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; addr = 64'd0; writeData = 64'd0;
    memWrite = 1'b0; memRead = 1'b0; i_sw = 16'h0000;
    step(2);
    reset = 1'b0;

    // Reset state
    rd("timer_rst", 64'h8018, 64'd0, 1'b1);
    check("led_rst", {48'd0, o_led}, 64'd0);
    check("blank_rst", {60'd0, o_disp_blank}, 64'hF);
    check("bcd_rst", {48'd0, o_disp_bcd}, 64'd0);
    rd("status_rst", 64'h8020, 64'd0, 1'b1);
    rd("sw_rst", 64'h8008, 64'd0, 1'b1);

    // LED and DISP
    wr(64'h8000, 64'hFFFF_FFFF_0001_A5A5);
    check("led_out", {48'd0, o_led}, 64'hA5A5);
    rd("led_rd", 64'h8000, 64'h0000_0000_0000_A5A5, 1'b1);
    wr(64'h8010, 64'h0000_0000_0005_2025);
    check("disp_bcd", {48'd0, o_disp_bcd}, 64'h2025);
    check("disp_blank", {60'd0, o_disp_blank}, 64'h5);
    rd("disp_rd", 64'h8010, 64'h5_2025, 1'b1);

    // Load and store to the same register in one cycle read the old value
    addr = 64'h8000; writeData = 64'h1111; memWrite = 1'b1; memRead = 1'b1;
    #2;
    check("rdw_old", readData, 64'hA5A5);
    step(1);
    memWrite = 1'b0; memRead = 1'b0;
    check("rdw_new", {48'd0, o_led}, 64'h1111);

    // Debounce: stable change appears after exactly 6 clocks
    i_sw = 16'h00F0;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      rd("sw_wait", 64'h8008, 64'd0, 1'b1);
    end
    step(1);
    rd("sw_upd", 64'h8008, 64'h00F0, 1'b1);
    rd("status_set", 64'h8020, 64'd1, 1'b1);

    // Clear STATUS
    wr(64'h8020, 64'd1);
    rd("status_clr", 64'h8020, 64'd0, 1'b1);

    // Two-cycle glitch must not reach SW nor set STATUS
    i_sw = 16'h0001;
    step(2);
    i_sw = 16'h00F0;
    step(10);
    rd("sw_glitch", 64'h8008, 64'h00F0, 1'b1);
    rd("status_glitch", 64'h8020, 64'd0, 1'b1);

    // Set wins over clear landing in the same cycle
    i_sw = 16'h0F00;
    step(5);
    rd("sw_pre", 64'h8008, 64'h00F0, 1'b1);
    wr(64'h8020, 64'd1);
    rd("sw_setclr", 64'h8008, 64'h0F00, 1'b1);
    rd("status_setwins", 64'h8020, 64'd1, 1'b1);

    // TIMER load and wrap
    wr(64'h8018, 64'hFFFF_FFFF_FFFF_FFFE);
    rd("timer_ld", 64'h8018, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    step(1);
    rd("timer_max", 64'h8018, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    step(1);
    rd("timer_wrap", 64'h8018, 64'd0, 1'b1);

    // Decode
    rd("miss_8028", 64'h8028, 64'd0, 1'b0);
    rd("miss_8004", 64'h8004, 64'd0, 1'b0);
    wr(64'h8008, 64'h1234);
    rd("sw_ro", 64'h8008, 64'h0F00, 1'b1);
    wr(64'h8004, 64'hBEEF);
    check("miss_wr_led", {48'd0, o_led}, 64'h1111);
    addr = 64'h8000; memRead = 1'b0;
    #2;
    check("noread_data", readData, 64'd0);
    check("noread_hit", {63'd0, hit}, 64'd1);

    // Reset overrides a simultaneous write
    step(1);
    reset = 1'b1; addr = 64'h8000; writeData = 64'hFFFF; memWrite = 1'b1;
    step(1);
    reset = 1'b0; memWrite = 1'b0;
    check("rst_over_wr", {48'd0, o_led}, 64'd0);
    check("rst_blank", {60'd0, o_disp_blank}, 64'hF);
    rd("rst_sw", 64'h8008, 64'd0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
